qdec_qp_fsm: RTL and testbench

CABAC sub-FSM that decodes the CU-level QP syntax group: `cu_qp_delta_abs`, `cu_qp_delta_sign_flag`, `cu_chroma_qp_offset_flag` and `cu_chroma_qp_offset_idx`. It replaces the chroma-only offset FSM with one parametrised block that:
- issues context-coded and bypass bin requests to the shared arithmetic decoder;
- binarises TR and EG0 codes;
- returns the signed `CuQpDeltaVal` and the chroma offset index to the CU-level FSM.

---
 rtl/qdec_qp_fsm_if.sv | 22 ++
 rtl/qdec_qp_fsm.sv | 195 +++++++++++++++++++
 tb/tb_qdec_qp_fsm.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qdec_qp_fsm_if.sv
// Bin request/response channel between a syntax sub-FSM (master) and the shared
// CABAC arithmetic decoder (slave).
interface qdec_qp_fsm_if #(
    parameter int CTX_AW = 10
) ();
    logic [CTX_AW-1:0] ctx_addr;
    logic              dec_run;
    logic              EPMode;
    logic              dec_rdy;
    logic              ruiBin;
    logic              ruiBin_vld;

    modport master (
        output ctx_addr, dec_run, EPMode,
        input  dec_rdy, ruiBin, ruiBin_vld
    );

    modport slave (
        input  ctx_addr, dec_run, EPMode,
        output dec_rdy, ruiBin, ruiBin_vld
    );
endinterface

// File: rtl/qdec_qp_fsm.sv
// CU-level QP syntax decoder: cu_qp_delta_abs/sign (TR + EG0) and, when built with
// QDEC_CHROMA_QP_OFFSET_EN, cu_chroma_qp_offset_flag/idx.
module qdec_qp_fsm #(
    parameter int CTX_AW        = 10,
    parameter int CTX_DQP       = 0,
    parameter int CTX_CQP_FLAG  = 2,
    parameter int CTX_CQP_IDX   = 3,
    parameter int EG_MAX_PREFIX = 6,
    parameter int DQP_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             qp_start,
    input  logic             dqp_en,
    input  logic             cqp_en,
    input  logic [2:0]       cqp_len_m1,
    qdec_qp_fsm_if.master    bus,
    output logic [DQP_W-1:0] cu_qp_delta_val,
    output logic             cu_chroma_qp_offset_flag,
    output logic [2:0]       cu_chroma_qp_offset_idx,
    output logic             qp_err,
    output logic             qp_done_intr
);
    localparam int NW = $clog2(EG_MAX_PREFIX + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DQP_PFX  = 3'd1,
        DQP_EGP  = 3'd2,
        DQP_EGS  = 3'd3,
        DQP_SIGN = 3'd4,
`ifdef QDEC_CHROMA_QP_OFFSET_EN
        CQP_FLAG = 3'd5,
        CQP_IDX  = 3'd6,
`endif
        DONE     = 3'd7
    } state_t;

    state_t            state;
    logic              pending;
    logic [2:0]        prefix;
    logic [NW-1:0]     n;
    logic [NW-1:0]     k;
    logic [DQP_W-1:0]  abs_val;
    state_t            chroma_exit;
    state_t            start_next;
    logic [CTX_AW-1:0] req_ctx;
    logic              req_ep;

`ifdef QDEC_CHROMA_QP_OFFSET_EN
    logic       cqp_en_r;
    logic [2:0] cqp_len_r;

    assign chroma_exit = cqp_en_r ? CQP_FLAG : DONE;
    assign start_next  = dqp_en ? DQP_PFX : (cqp_en ? CQP_FLAG : DONE);
`else
    logic unused_cqp;

    assign unused_cqp               = ^{cqp_en, cqp_len_m1};
    assign chroma_exit              = DONE;
    assign start_next               = dqp_en ? DQP_PFX : DONE;
    assign cu_chroma_qp_offset_flag = 1'b0;
    assign cu_chroma_qp_offset_idx  = 3'd0;
`endif

    // Bypass bins carry no context; ctx_addr reads 0 for them.
    always_comb begin
        req_ep  = 1'b1;
        req_ctx = '0;
        case (state)
            DQP_PFX: begin
                req_ep  = 1'b0;
                req_ctx = (prefix == 3'd0) ? CTX_AW'(CTX_DQP) : CTX_AW'(CTX_DQP + 1);
            end
`ifdef QDEC_CHROMA_QP_OFFSET_EN
            CQP_FLAG: begin
                req_ep  = 1'b0;
                req_ctx = CTX_AW'(CTX_CQP_FLAG);
            end
            CQP_IDX: begin
                req_ep  = 1'b0;
                req_ctx = CTX_AW'(CTX_CQP_IDX);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            pending         <= 1'b0;
            prefix          <= 3'd0;
            n               <= '0;
            k               <= '0;
            abs_val         <= '0;
            bus.dec_run     <= 1'b0;
            bus.ctx_addr    <= '0;
            bus.EPMode      <= 1'b0;
            cu_qp_delta_val <= '0;
            qp_err          <= 1'b0;
            qp_done_intr    <= 1'b0;
`ifdef QDEC_CHROMA_QP_OFFSET_EN
            cqp_en_r                 <= 1'b0;
            cqp_len_r                <= 3'd0;
            cu_chroma_qp_offset_flag <= 1'b0;
            cu_chroma_qp_offset_idx  <= 3'd0;
`endif
        end else begin
            bus.dec_run  <= 1'b0;
            qp_done_intr <= 1'b0;
            if (state == IDLE) begin
                if (qp_start) begin
                    state           <= start_next;
                    pending         <= 1'b0;
                    prefix          <= 3'd0;
                    n               <= '0;
                    k               <= '0;
                    abs_val         <= '0;
                    cu_qp_delta_val <= '0;
                    qp_err          <= 1'b0;
`ifdef QDEC_CHROMA_QP_OFFSET_EN
                    cqp_en_r                 <= cqp_en;
                    cqp_len_r                <= cqp_len_m1;
                    cu_chroma_qp_offset_flag <= 1'b0;
                    cu_chroma_qp_offset_idx  <= 3'd0;
`endif
                end
            end else if (state == DONE) begin
                qp_done_intr <= 1'b1;
                state        <= IDLE;
            end else if (!pending) begin
                if (bus.dec_rdy) begin
                    bus.dec_run  <= 1'b1;
                    bus.ctx_addr <= req_ctx;
                    bus.EPMode   <= req_ep;
                    pending      <= 1'b1;
                end
            end else if (bus.ruiBin_vld) begin
                pending <= 1'b0;
                case (state)
                    DQP_PFX: begin
                        if (bus.ruiBin) begin
                            prefix <= prefix + 3'd1;
                            if (prefix == 3'd4) state <= DQP_EGP;
                        end else if (prefix != 3'd0) begin
                            abs_val <= DQP_W'(prefix);
                            state   <= DQP_SIGN;
                        end else begin
                            state <= chroma_exit;
                        end
                    end
                    DQP_EGP: begin
                        if (bus.ruiBin) begin
                            n <= n + NW'(1);
                            if (n == NW'(EG_MAX_PREFIX - 1)) begin
                                qp_err <= 1'b1;
                                state  <= DONE;
                            end
                        end else begin
                            // 5 + (1<<n) - 1, suffix bits are added in DQP_EGS
                            abs_val <= DQP_W'(4) + (DQP_W'(1) << n);
                            k       <= '0;
                            state   <= (n == '0) ? DQP_SIGN : DQP_EGS;
                        end
                    end
                    DQP_EGS: begin
                        abs_val <= abs_val + (DQP_W'(bus.ruiBin) << (n - k - NW'(1)));
                        k       <= k + NW'(1);
                        if (k == n - NW'(1)) state <= DQP_SIGN;
                    end
                    DQP_SIGN: begin
                        cu_qp_delta_val <= bus.ruiBin ? (DQP_W'(0) - abs_val) : abs_val;
                        state           <= chroma_exit;
                    end
`ifdef QDEC_CHROMA_QP_OFFSET_EN
                    CQP_FLAG: begin
                        cu_chroma_qp_offset_flag <= bus.ruiBin;
                        state <= (bus.ruiBin && cqp_len_r != 3'd0) ? CQP_IDX : DONE;
                    end
                    CQP_IDX: begin
                        if (bus.ruiBin) begin
                            cu_chroma_qp_offset_idx <= cu_chroma_qp_offset_idx + 3'd1;
                            if (cu_chroma_qp_offset_idx + 3'd1 == cqp_len_r) state <= DONE;
                        end else begin
                            state <= DONE;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qdec_qp_fsm.sv
// Bench for qdec_qp_fsm: directed and random bin streams checked against a
// syntax-level model of the QP group decode.
`timescale 1ns/1ps
module tb_qdec_qp_fsm;
    localparam int CTX_AW       = 10;
    localparam int CTX_DQP      = 0;
    localparam int CTX_CQP_FLAG = 2;
    localparam int CTX_CQP_IDX  = 3;
    localparam int EG_MAX       = 6;
    localparam int DQP_W        = 8;
`ifdef QDEC_CHROMA_QP_OFFSET_EN
    localparam bit CHROMA = 1'b1;
`else
    localparam bit CHROMA = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             qp_start = 1'b0;
    logic             dqp_en = 1'b0;
    logic             cqp_en = 1'b0;
    logic [2:0]       cqp_len_m1 = 3'd0;
    logic [DQP_W-1:0] cu_qp_delta_val;
    logic             cqp_flag;
    logic [2:0]       cqp_idx;
    logic             qp_err;
    logic             qp_done_intr;

    qdec_qp_fsm_if #(.CTX_AW(CTX_AW)) bus ();

    qdec_qp_fsm #(
        .CTX_AW(CTX_AW), .CTX_DQP(CTX_DQP), .CTX_CQP_FLAG(CTX_CQP_FLAG),
        .CTX_CQP_IDX(CTX_CQP_IDX), .EG_MAX_PREFIX(EG_MAX), .DQP_W(DQP_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .qp_start(qp_start), .dqp_en(dqp_en),
        .cqp_en(cqp_en), .cqp_len_m1(cqp_len_m1), .bus(bus),
        .cu_qp_delta_val(cu_qp_delta_val), .cu_chroma_qp_offset_flag(cqp_flag),
        .cu_chroma_qp_offset_idx(cqp_idx), .qp_err(qp_err), .qp_done_intr(qp_done_intr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // decoder stand-in: random latency, optional random dec_rdy and stray ruiBin_vld
    bit                bin_q[$];
    logic [CTX_AW-1:0] log_ctx[$];
    bit                log_ep[$];
    int                dup_cnt = 0;
    bit                rdy_low = 1'b0;
    bit                rdy_rand = 1'b0;
    bit                spur = 1'b0;
    bit                flush = 1'b0;

    initial begin
        bit busy;
        int cnt;
        busy = 1'b0;
        cnt = 0;
        bus.dec_rdy = 1'b1;
        bus.ruiBin = 1'b0;
        bus.ruiBin_vld = 1'b0;
        forever begin
            @(negedge clk);
            bus.ruiBin_vld = 1'b0;
            if (flush) begin
                busy = 1'b0;
                bin_q.delete();
            end else begin
                if (bus.dec_run) begin
                    if (busy) dup_cnt++;
                    else begin
                        log_ctx.push_back(bus.ctx_addr);
                        log_ep.push_back(bus.EPMode);
                        busy = 1'b1;
                        cnt = $urandom_range(0, 3);
                    end
                end
                if (busy) begin
                    if (cnt == 0) begin
                        bus.ruiBin_vld = 1'b1;
                        bus.ruiBin = (bin_q.size() > 0) ? bin_q.pop_front() : 1'b0;
                        busy = 1'b0;
                    end else cnt--;
                end else if (spur && !bus.dec_run && $urandom_range(0, 5) == 0) begin
                    bus.ruiBin_vld = 1'b1;
                    bus.ruiBin = 1'($urandom_range(0, 1));
                end
            end
            bus.dec_rdy = rdy_low ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // reference model: walks the bin stream through the syntax rules
    bit                stim[$];
    int                sp;
    logic [CTX_AW-1:0] e_ctx[$];
    bit                e_ep[$];
    logic [DQP_W-1:0]  m_delta;
    bit                m_flag;
    logic [2:0]        m_idx;
    bit                m_err;

    function automatic bit take(input int ctx, input bit ep);
        e_ctx.push_back(CTX_AW'(ctx));
        e_ep.push_back(ep);
        sp++;
        return (sp - 1 < stim.size()) ? stim[sp-1] : 1'b0;
    endfunction

    task automatic model(input bit den, input bit cen, input int len);
        int pre, n, suf, absv;
        e_ctx.delete(); e_ep.delete(); sp = 0;
        m_delta = '0; m_flag = 1'b0; m_idx = 3'd0; m_err = 1'b0;
        if (den) begin
            pre = 0;
            while (pre < 5 && take(pre == 0 ? CTX_DQP : CTX_DQP + 1, 1'b0)) pre++;
            absv = pre;
            if (pre == 5) begin
                n = 0;
                while (take(0, 1'b1)) begin
                    n++;
                    if (n == EG_MAX) begin m_err = 1'b1; return; end
                end
                suf = 0;
                for (int i = 0; i < n; i++) suf = suf * 2 + int'(take(0, 1'b1));
                absv = 5 + (1 << n) - 1 + suf;
            end
            if (absv > 0) m_delta = take(0, 1'b1) ? DQP_W'(-absv) : DQP_W'(absv);
        end
        if (cen && CHROMA) begin
            m_flag = take(CTX_CQP_FLAG, 1'b0);
            if (m_flag) while (int'(m_idx) < len && take(CTX_CQP_IDX, 1'b0)) m_idx++;
        end
    endtask

    task automatic run(input string tag, input bit den, input bit cen, input int len,
                       input bit hold_rdy, input bit restart, output int lat);
        bit seen, do_rs;
        int d0, ne;
        model(den, cen, len);
        do_rs = restart && (e_ctx.size() >= 3);
        bin_q = stim;
        log_ctx.delete(); log_ep.delete();
        d0 = dup_cnt;
        @(negedge clk);
        dqp_en = den; cqp_en = cen; cqp_len_m1 = 3'(len); qp_start = 1'b1; rdy_low = hold_rdy;
        lat = 0; seen = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            qp_start = 1'b0;
            lat++;
            dqp_en = 1'($urandom_range(0, 1));
            cqp_en = 1'($urandom_range(0, 1));
            cqp_len_m1 = 3'($urandom_range(0, 5));
            if (lat == 1)
                chk({tag, " clr"}, 32'({qp_err, cqp_flag, cqp_idx, cu_qp_delta_val}), 0);
            if (hold_rdy && lat == 6) begin
                chk({tag, " rdy_hold"}, log_ctx.size(), 0);
                rdy_low = 1'b0;
            end
            if (qp_done_intr) begin seen = 1'b1; break; end
            if (do_rs && lat == 4) qp_start = 1'b1;
        end
        qp_start = 1'b0;
        chk({tag, " done"}, 32'(seen), 1);
        chk({tag, " delta"}, 32'(cu_qp_delta_val), 32'(m_delta));
        chk({tag, " flag"}, 32'(cqp_flag), 32'(m_flag));
        chk({tag, " idx"}, 32'(cqp_idx), 32'(m_idx));
        chk({tag, " err"}, 32'(qp_err), 32'(m_err));
        chk({tag, " nreq"}, log_ctx.size(), e_ctx.size());
        ne = (log_ctx.size() < e_ctx.size()) ? log_ctx.size() : e_ctx.size();
        for (int i = 0; i < ne; i++) begin
            chk($sformatf("%s ep%0d", tag, i), 32'(log_ep[i]), 32'(e_ep[i]));
            if (!e_ep[i]) chk($sformatf("%s ctx%0d", tag, i), 32'(log_ctx[i]), 32'(e_ctx[i]));
        end
        chk({tag, " dup"}, dup_cnt - d0, 0);
        @(negedge clk);
        chk({tag, " pulse"}, 32'(qp_done_intr), 0);
    endtask

    initial begin
        int lat, nreq;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outs", 32'({qp_err, qp_done_intr, cqp_flag, cqp_idx, cu_qp_delta_val}), 0);
        chk("reset run", 32'(bus.dec_run), 0);
        rst_n = 1'b1;

        stim.delete();
        run("none", 1'b0, 1'b0, 0, 1'b0, 1'b0, lat);
        chk("none lat", lat, 2);

        stim = '{0};
        run("dqp0", 1'b1, 1'b0, 0, 1'b0, 1'b0, lat);

        stim = '{1, 1, 0, 1};
        run("dqp_m2", 1'b1, 1'b0, 0, 1'b0, 1'b0, lat);
        chk("dqp_m2 abs", 32'(cu_qp_delta_val), 32'hFE);

        stim = '{1, 1, 1, 1, 1, 1, 0, 1, 0};
        run("dqp_p7", 1'b1, 1'b0, 0, 1'b0, 1'b0, lat);
        chk("dqp_p7 abs", 32'(cu_qp_delta_val), 7);

        rst_n = 1'b0;
        @(negedge clk);
        chk("rst clears", 32'({qp_err, cqp_flag, cqp_idx, cu_qp_delta_val}), 0);
        rst_n = 1'b1;

        stim = '{1, 1, 1, 1};
        run("cqp", 1'b0, 1'b1, 3, 1'b0, 1'b0, lat);

        stim = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        run("egerr", 1'b1, 1'b0, 0, 1'b1, 1'b0, lat);
        chk("egerr flag", 32'(qp_err), 1);

        stim = '{0, 1, 1, 1};
        run("dqp_cqp", 1'b1, 1'b1, 2, 1'b0, 1'b0, lat);

        // reset in the middle of a decode
        stim.delete();
        for (int i = 0; i < 40; i++) stim.push_back(1'b1);
        bin_q = stim;
        log_ctx.delete(); log_ep.delete();
        @(negedge clk);
        dqp_en = 1'b1; cqp_en = 1'b1; cqp_len_m1 = 3'd5; qp_start = 1'b1;
        @(negedge clk);
        qp_start = 1'b0;
        for (int c = 0; c < 300 && log_ctx.size() < 3; c++) @(negedge clk);
        chk("rst_mid reached", 32'(log_ctx.size() >= 3), 1);
        rst_n = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("rst_mid outs", 32'({qp_err, qp_done_intr, cqp_flag, cqp_idx, cu_qp_delta_val}), 0);
        chk("rst_mid run", 32'(bus.dec_run), 0);
        rst_n = 1'b1;
        nreq = log_ctx.size();
        repeat (10) @(negedge clk);
        chk("rst_mid idle", log_ctx.size(), nreq);

        stim = '{1, 0, 0};
        run("post_rst", 1'b1, 1'b0, 0, 1'b0, 1'b0, lat);

        rdy_rand = 1'b1;
        spur = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int pr;
            pr = $urandom_range(1, 3);
            stim.delete();
            for (int i = 0; i < 32; i++) stim.push_back($urandom_range(0, 3) < pr);
            run($sformatf("rnd%0d", t), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 5), 1'b0, 1'b1, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
